// File: rtl/uio_bus_scheduler_if.sv
// Bundle between the stream sources/external receive path and the uio pad scheduler.
//   ena        : design selected; low aborts or suppresses bus activity
//   req        : per-requester word ready
//   req_data   : per-requester word, requester i at [8i+7:8i]
//   req_last   : per-requester last-word-of-burst flag
//   gnt        : one-hot, word of requester i consumed this cycle
//   rx_req     : external peer drives uio_in this cycle
//   uio_in     : pad input
//   uio_out    : pad output (registered)
//   uio_oe     : pad enable (registered, 8'h00 or 8'hFF)
//   rx_data    : captured inbound word (registered)
//   rx_valid   : rx_data updated this cycle
//   busy       : scheduler not idle
interface uio_bus_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic                ena;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     gnt;
  logic                rx_req;
  logic [7:0]          uio_in;
  logic [7:0]          uio_out;
  logic [7:0]          uio_oe;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                busy;

  // Source / pad side.
  modport master (
    output ena, req, req_data, req_last, rx_req, uio_in,
    input  gnt, uio_out, uio_oe, rx_data, rx_valid, busy
  );

  // Scheduler side.
  modport slave (
    input  ena, req, req_data, req_last, rx_req, uio_in,
    output gnt, uio_out, uio_oe, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/uio_bus_scheduler.sv
// Schedules the shared 8-bit bidirectional uio pad bus between NREQ transmit
// streams (round-robin bursts) and one external receive stream, inserting a
// turnaround gap after every transmit burst.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uio_bus_scheduler_if.slave (requests, grants, pads, receive path)
module uio_bus_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TURN      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uio_bus_scheduler_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_TX   = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      uio_out_q, uio_out_d;
  logic [7:0]      uio_oe_q, uio_oe_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [NREQ-1:0] gnt_c;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt_inc;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(last_q) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state, pad and receive-path decisions.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    uio_out_d  = uio_out_q;
    uio_oe_d   = 8'h00;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    gnt_c      = '0;
    cnt_inc    = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.ena && bus.rx_req) begin
          state_d = S_RX;
        end else if (bus.ena && found) begin
          state_d = S_TX;
          win_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      S_RX: begin
        if (bus.ena && bus.rx_req) begin
          rx_data_d  = bus.uio_in;
          rx_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (bus.ena && bus.req[win_q]) begin
          gnt_c[win_q] = 1'b1;
          uio_out_d    = bus.req_data[{win_q, 3'b000} +: 8];
          uio_oe_d     = 8'hFF;
          cnt_d        = cnt_inc;
          if (bus.req_last[win_q] || (cnt_inc == CW'(MAX_BURST))) begin
            state_d = S_TURN;
            tcnt_d  = '0;
          end
        end else begin
          // Requester withdrew or design deselected: close the burst.
          state_d = S_TURN;
          tcnt_d  = '0;
        end
      end
      S_TURN: begin
        if (tcnt_q == TW'(TURN)) begin
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      cnt_q      <= '0;
      tcnt_q     <= '0;
      uio_out_q  <= 8'h00;
      uio_oe_q   <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.uio_out  = uio_out_q;
  assign bus.uio_oe   = uio_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Directed bench for uio_bus_scheduler (NREQ=4, MAX_BURST=8, TURN=1).
module tb_uio_bus_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TURN = 1;

  logic clk;
  logic rst_n;

  uio_bus_scheduler_if #(.NREQ(NREQ)) bus ();

  uio_bus_scheduler #(
    .NREQ      (NREQ),
    .MAX_BURST (8),
    .TURN      (TURN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests;
  int         n_fail;
  logic [3:0] gv;
  logic [3:0] prev_g;
  logic [7:0] pend;
  logic       exp_drive;
  int         gnt_order[$];
  int         gnt_cnt[4];
  int         beat[4];
  int         auto_len;
  int         gap_run;
  int         min_gap;
  bit         seen_drive;
  int         exp_rr[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Commit what the next edge consumes, then sample the following cycle at negedge.
  task automatic step();
    logic [3:0] g;
    #1;
    g = bus.gnt;
    exp_drive = (g != 4'd0);
    if (exp_drive) begin
      check("gnt_onehot", 32'($onehot(g) && ((g & bus.req) == g)), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          pend = bus.req_data[8*i +: 8];
          if (g != prev_g) gnt_order.push_back(i);
          gnt_cnt[i]++;
          if (auto_len != 0) beat[i] = (beat[i] + 1) % auto_len;
        end
      end
    end
    prev_g = g;
    @(negedge clk);
    gv = bus.gnt;
    check("pad_oe", 32'(bus.uio_oe), exp_drive ? 32'hFF : 32'h00);
    if (exp_drive) check("pad_out", 32'(bus.uio_out), 32'(pend));
    if (bus.uio_oe == 8'hFF) begin
      if (seen_drive && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
      seen_drive = 1'b1;
      gap_run = 0;
    end else begin
      gap_run++;
    end
    if (auto_len != 0) begin
      for (int i = 0; i < 4; i++) bus.req_last[i] = (beat[i] == auto_len - 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  task automatic clear_stats();
    gnt_order.delete();
    for (int i = 0; i < 4; i++) begin
      gnt_cnt[i] = 0;
      beat[i] = 0;
    end
    min_gap = 1000;
    gap_run = 0;
    seen_drive = 1'b0;
    prev_g = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    auto_len = 0;
    pend = 8'h00;
    exp_drive = 1'b0;
    gv = 4'd0;
    clear_stats();
    exp_rr = '{0, 1, 3, 0, 1};
    bus.ena = 1'b0;
    bus.req = 4'd0;
    bus.req_data = 32'd0;
    bus.req_last = 4'd0;
    bus.rx_req = 1'b0;
    bus.uio_in = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_oe", 32'(bus.uio_oe), 32'h00);
    check("rst_out", 32'(bus.uio_out), 32'h00);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    rst_n = 1'b1;

    // Reset mid-burst releases the bus at once; requester 0 wins afterwards
    bus.ena = 1'b1;
    bus.req = 4'hF;
    bus.req_data = 32'h44332211;
    step();
    check("rst_first_gnt", 32'(gv), 32'h1);
    step();
    check("rst_burst_oe", 32'(bus.uio_oe), 32'hFF);
    check("rst_burst_out", 32'(bus.uio_out), 32'h11);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_oe", 32'(bus.uio_oe), 32'h00);
    check("rst_async_gnt", 32'(bus.gnt), 32'd0);
    check("rst_async_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_regrant", 32'(gv), 32'h1);
    bus.req = 4'd0;
    wait_idle();

    // Single three-word burst from requester 0
    bus.req = 4'b0001;
    bus.req_data = 32'h00000011;
    bus.req_last = 4'd0;
    step();
    check("sb_gnt", 32'(gv), 32'h1);
    check("sb_oe_idle", 32'(bus.uio_oe), 32'h00);
    step();
    check("sb_out1", 32'(bus.uio_out), 32'h11);
    bus.req_data = 32'h00000022;
    step();
    check("sb_out2", 32'(bus.uio_out), 32'h22);
    bus.req_data = 32'h00000033;
    bus.req_last = 4'b0001;
    step();
    check("sb_out3", 32'(bus.uio_out), 32'h33);
    check("sb_oe3", 32'(bus.uio_oe), 32'hFF);
    check("sb_gnt_turn", 32'(gv), 32'd0);
    check("sb_busy_turn", 32'(bus.busy), 32'd1);
    bus.req = 4'd0;
    bus.req_last = 4'd0;
    step();
    check("sb_oe_turn", 32'(bus.uio_oe), 32'h00);
    check("sb_busy_turn2", 32'(bus.busy), 32'd1);
    step();
    check("sb_busy_idle", 32'(bus.busy), 32'd0);

    // Round robin over requesters 0,1,3 with two-word bursts
    do_reset();
    clear_stats();
    auto_len = 2;
    bus.req_data = 32'hD3C2B1A0;
    bus.req_last = 4'd0;
    bus.req = 4'b1011;
    for (int n = 0; n < 100 && gnt_order.size() < 5; n++) step();
    check("rr_bursts", 32'(gnt_order.size()), 32'd5);
    if (gnt_order.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", 32'(gnt_order[k]), 32'(exp_rr[k]));
    end
    check("rr_cnt0", 32'(gnt_cnt[0]), 32'd4);
    check("rr_cnt3", 32'(gnt_cnt[3]), 32'd2);
    check("rr_gap", 32'(min_gap >= int'(TURN) + 1), 32'd1);
    bus.req = 4'd0;
    auto_len = 0;
    bus.req_last = 4'd0;
    wait_idle();

    // Burst cap: requester 2 never flags last
    clear_stats();
    bus.req_data = 32'h005C0000;
    bus.req = 4'b0100;
    for (int n = 0; n < 60 && gnt_order.size() < 2; n++) step();
    check("cap_regrant", 32'(gnt_order.size()), 32'd2);
    check("cap_pulses", 32'(gnt_cnt[2]), 32'd9);
    check("cap_gap", 32'(min_gap >= int'(TURN) + 1), 32'd1);
    bus.req = 4'd0;
    wait_idle();

    // Receive has priority over a simultaneous transmit request
    bus.rx_req = 1'b1;
    bus.req = 4'b0010;
    bus.req_data = 32'h00006600;
    bus.uio_in = 8'hA5;
    step();
    check("rx_enter_busy", 32'(bus.busy), 32'd1);
    check("rx_enter_valid", 32'(bus.rx_valid), 32'd0);
    check("rx_enter_gnt", 32'(gv), 32'd0);
    step();
    check("rx_valid1", 32'(bus.rx_valid), 32'd1);
    check("rx_data1", 32'(bus.rx_data), 32'hA5);
    bus.uio_in = 8'h5A;
    step();
    check("rx_valid2", 32'(bus.rx_valid), 32'd1);
    check("rx_data2", 32'(bus.rx_data), 32'h5A);
    check("rx_oe", 32'(bus.uio_oe), 32'h00);
    bus.rx_req = 1'b0;
    step();
    check("rx_exit_valid", 32'(bus.rx_valid), 32'd0);
    check("rx_hold_data", 32'(bus.rx_data), 32'h5A);
    check("rx_exit_busy", 32'(bus.busy), 32'd0);
    step();
    check("rx_then_tx_gnt", 32'(gv), 32'h2);
    bus.req = 4'd0;
    wait_idle();

    // Abort by deselecting mid-burst
    bus.req = 4'b0001;
    bus.req_data = 32'h00000077;
    step();
    check("ab_gnt", 32'(gv), 32'h1);
    step();
    check("ab_out", 32'(bus.uio_out), 32'h77);
    bus.ena = 1'b0;
    #1;
    check("ab_gnt_off", 32'(bus.gnt), 32'd0);
    step();
    check("ab_oe_off", 32'(bus.uio_oe), 32'h00);
    check("ab_turn1", 32'(bus.busy), 32'd1);
    step();
    check("ab_turn2", 32'(bus.busy), 32'd1);
    step();
    check("ab_idle", 32'(bus.busy), 32'd0);
    step();
    check("ab_stay_idle", 32'(bus.busy), 32'd0);
    check("ab_no_gnt", 32'(gv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uio_bus_scheduler.md
# uio_bus_scheduler

Schedules the shared 8-bit bidirectional `uio` pad bus of the maxbw top level between NREQ internal transmit streams and one external receive stream. It owns `uio_out`/`uio_oe`, grants bursts round-robin, enforces a bus-turnaround gap before the direction may change, and captures inbound words from `uio_in`. It sits directly between the stream sources inside the top level and the TinyTapeout `uio_*` pins.

## Interface

- `NREQ`, 4: number of transmit requesters (2..8).
- `MAX_BURST`, 8: maximum words per granted burst (1..255).
- `TURN`, 1: idle cycles with `uio_oe`=0 after a burst (0..7).

- `clk` in 1: sole clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design selected; low aborts/suppresses activity.
- `req` in NREQ: requester i has a word ready.
- `req_data` in 8*NREQ: word of requester i at bits [8i+7:8i].
- `req_last` in NREQ: word of requester i is last of its burst.
- `gnt` out NREQ: one-hot; word of requester i consumed this cycle.
- `rx_req` in 1: external peer drives `uio_in` this cycle (from a `ui_in` pin).
- `uio_in` in 8: pad input.
- `uio_out` out 8: pad output, registered.
- `uio_oe` out 8: pad enable, registered, always 8'h00 or 8'hFF.
- `rx_data` out 8: captured inbound word, registered.
- `rx_valid` out 1: `rx_data` updated this cycle.
- `busy` out 1: state is not IDLE.

## Operation

- States: IDLE, RX, TX, TURN.
- IDLE: `uio_oe`=0. If `ena` and `rx_req` -> RX (receive has priority). Else if `ena` and any `req` -> TX with winner chosen round-robin: search from `last+1` modulo NREQ; `last` updated to winner. Else stay.
- RX: each cycle `rx_req`=1 latches `uio_in` into `rx_data`, `rx_valid`=1 next cycle. `rx_req`=0 or `ena`=0 -> IDLE (no turnaround needed; bus never driven).
- TX: `gnt[w]` = `req[w]` (combinational, winner only, zero if `ena`=0). On each granted cycle: `uio_out`<=`req_data[w]`, `uio_oe`<=8'hFF, burst count +1. Burst ends (-> TURN) on the granted cycle where `req_last[w]`=1 or count reaches MAX_BURST, or on any cycle with `req[w]`=0 or `ena`=0. Non-granted cycle: `uio_oe`<=0.
- TURN: lasts exactly TURN+1 cycles; `uio_oe`<=0 from its first edge; then -> IDLE. `rx_req` and `req` ignored in TX and TURN.
- Burst count resets to 0 on TX entry; 8-bit, never exceeds MAX_BURST.
- `uio_out` holds its last value when not driven.

## Timing

- Reset (async, immediate): state IDLE, `uio_oe`=0, `uio_out`=0, `rx_data`=0, `rx_valid`=0, `gnt`=0, `last`=NREQ-1 (requester 0 wins first), count 0. Reset mid-burst releases bus in the same instant.
- Arbitration: `req` seen in IDLE at edge N -> TX from N; first `gnt` in cycle N..N+1; word on pins with `uio_oe`=FF one cycle after its `gnt`.
- Back-to-back: a word per cycle while `req` held; last word visible on pins during first TURN cycle, `uio_oe` low from the next edge.
- Minimum gap between the last driven cycle of one burst and the first driven cycle of the next: TURN+1 cycles with `uio_oe`=0.
- RX latency: `uio_in` sampled at edge where `rx_req`=1 (in RX) -> `rx_data`/`rx_valid` valid the following cycle. The IDLE->RX edge does not capture.
- Simultaneous `rx_req` and `req` in IDLE: RX wins; TX requests wait.

## Test plan

- Reset: drive `req`=4'hF, assert `rst_n`=0 mid-burst -> `uio_oe`=00 and `gnt`=0 immediately; after release first grant goes to requester 0.
- Single burst: req0 with data 0x11,0x22,0x33, `req_last` on 0x33 -> `uio_out` 11,22,33 on consecutive cycles with `uio_oe`=FF, then `uio_oe`=00 for TURN+1 cycles, `busy` low after.
- Round robin: `req`=4'b1011 held, bursts of 2 -> grant order 0,1,3,0,1 with TURN+1 idle gap between bursts.
- Burst cap: req2 held with no `req_last`, MAX_BURST=8 -> exactly 8 `gnt[2]` pulses, then TURN, then re-grant.
- Receive priority: `rx_req` and `req1` rise together, `uio_in`=0xA5,0x5A -> `rx_data` A5 then 5A with `rx_valid`, `uio_oe` stays 00; TX starts after `rx_req` drops.
- Abort: `ena`=0 during TX -> no further `gnt`, `uio_oe`=00 next edge, TURN observed before IDLE.
